// File: rtl/eeg_aram_lane_init_if.sv
// rtl/eeg_aram_lane_init_if.sv - engine/bank signal bundle for one ARAM lane initiator
interface eeg_aram_lane_init_if #(
    parameter int ADD_AW = 12,
    parameter int DAT_DW = 8,
    parameter int LEN_DW = 12
);
    logic              is_idle;
    logic              cfg_info_vld;
    logic              cfg_info_rdy;
    logic [1:0]        cfg_info_cmd;
    logic [ADD_AW-1:0] cfg_base_add;
    logic [LEN_DW-1:0] cfg_len_m1;
    logic              src_dat_vld;
    logic              src_dat_rdy;
    logic [DAT_DW-1:0] src_dat_dat;
    logic              etoa_dat_vld;
    logic              etoa_dat_lst;
    logic              etoa_dat_rdy;
    logic [ADD_AW-1:0] etoa_dat_add;
    logic [DAT_DW-1:0] etoa_dat_dat;
    logic              etoa_add_vld;
    logic              etoa_add_lst;
    logic              etoa_add_rdy;
    logic [ADD_AW-1:0] etoa_add_add;
    logic              atoe_dat_vld;
    logic              atoe_dat_lst;
    logic              atoe_dat_rdy;
    logic [DAT_DW-1:0] atoe_dat_dat;
    logic              dst_dat_vld;
    logic              dst_dat_lst;
    logic              dst_dat_rdy;
    logic [DAT_DW-1:0] dst_dat_dat;

    modport slave (
        output is_idle, cfg_info_rdy, src_dat_rdy,
        output etoa_dat_vld, etoa_dat_lst, etoa_dat_add, etoa_dat_dat,
        output etoa_add_vld, etoa_add_lst, etoa_add_add,
        output atoe_dat_rdy, dst_dat_vld, dst_dat_lst, dst_dat_dat,
        input  cfg_info_vld, cfg_info_cmd, cfg_base_add, cfg_len_m1,
        input  src_dat_vld, src_dat_dat, etoa_dat_rdy, etoa_add_rdy,
        input  atoe_dat_vld, atoe_dat_lst, atoe_dat_dat, dst_dat_rdy
    );

    modport master (
        input  is_idle, cfg_info_rdy, src_dat_rdy,
        input  etoa_dat_vld, etoa_dat_lst, etoa_dat_add, etoa_dat_dat,
        input  etoa_add_vld, etoa_add_lst, etoa_add_add,
        input  atoe_dat_rdy, dst_dat_vld, dst_dat_lst, dst_dat_dat,
        output cfg_info_vld, cfg_info_cmd, cfg_base_add, cfg_len_m1,
        output src_dat_vld, src_dat_dat, etoa_dat_rdy, etoa_add_rdy,
        output atoe_dat_vld, atoe_dat_lst, atoe_dat_dat, dst_dat_rdy
    );
endinterface

// File: rtl/eeg_aram_lane_init.sv
// rtl/eeg_aram_lane_init.sv - single-lane ARAM bank initiator (write pass-through, credit-bounded read)
module eeg_aram_lane_init #(
    parameter int ARAM_ADD_AW = 12,
    parameter int ARAM_DAT_DW = 8,
    parameter int ARAM_LEN_DW = 12,
    parameter int MAX_OUTSTD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eeg_aram_lane_init_if.slave   bus
);
    localparam int AW = ARAM_ADD_AW;
    localparam int DW = ARAM_DAT_DW;
    localparam int LW = ARAM_LEN_DW;
    localparam int PW = $clog2(MAX_OUTSTD);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    state_t          state;
    logic [AW-1:0]   base;
    logic [LW-1:0]   len_m1;
    logic [LW-1:0]   wcnt;
    logic [LW-1:0]   dcnt;
    logic [LW:0]     acnt;
    logic [CW-1:0]   ost;
    logic [CW-1:0]   fcnt;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [DW:0]     mem [MAX_OUTSTD];

    logic is_wr, is_rd, cfg_fire, wr_fire, add_fire, ret_fire, dst_fire, dst_lst_exp;

    assign is_wr    = (state == ST_WR);
    assign is_rd    = (state == ST_RD);
    assign cfg_fire = (state == ST_IDLE) && bus.cfg_info_vld;

    assign bus.is_idle      = (state == ST_IDLE);
    assign bus.cfg_info_rdy = (state == ST_IDLE);

    // Write path is a straight combinational pass between source and bank.
    assign bus.src_dat_rdy  = is_wr && bus.etoa_dat_rdy;
    assign bus.etoa_dat_vld = is_wr && bus.src_dat_vld;
    assign bus.etoa_dat_add = is_wr ? base + AW'(wcnt) : '0;
    assign bus.etoa_dat_dat = is_wr ? bus.src_dat_dat : '0;
    assign bus.etoa_dat_lst = bus.etoa_dat_vld && (wcnt == len_m1);

    // acnt is one bit wider so "all issued" (len_m1+1) is representable at full length.
    assign bus.etoa_add_vld = is_rd && (acnt <= {1'b0, len_m1}) && (ost < CW'(MAX_OUTSTD));
    assign bus.etoa_add_add = bus.etoa_add_vld ? base + AW'(acnt) : '0;
    assign bus.etoa_add_lst = bus.etoa_add_vld && (acnt == {1'b0, len_m1});

    assign bus.atoe_dat_rdy = is_rd;
    assign bus.dst_dat_vld  = is_rd && (fcnt != '0);
    assign bus.dst_dat_dat  = bus.dst_dat_vld ? mem[rptr][DW-1:0] : '0;
    assign dst_lst_exp      = (dcnt == len_m1);
    assign bus.dst_dat_lst  = bus.dst_dat_vld && dst_lst_exp;

    assign wr_fire  = bus.etoa_dat_vld && bus.etoa_dat_rdy;
    assign add_fire = bus.etoa_add_vld && bus.etoa_add_rdy;
    assign ret_fire = is_rd && bus.atoe_dat_vld;
    assign dst_fire = bus.dst_dat_vld && bus.dst_dat_rdy;

    always_ff @(posedge clk) begin
        if (ret_fire) mem[wptr] <= {bus.atoe_dat_lst, bus.atoe_dat_dat};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            base   <= '0;
            len_m1 <= '0;
            wcnt   <= '0;
            dcnt   <= '0;
            acnt   <= '0;
            ost    <= '0;
            fcnt   <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        base   <= bus.cfg_base_add;
                        len_m1 <= bus.cfg_len_m1;
                        if (bus.cfg_info_cmd == 2'b01)      state <= ST_WR;
                        else if (bus.cfg_info_cmd == 2'b10) state <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (wr_fire) begin
                        if (bus.etoa_dat_lst) begin
                            wcnt  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            wcnt <= wcnt + LW'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (add_fire) acnt <= acnt + (LW+1)'(1);
                    if (ret_fire) wptr <= wptr + PW'(1);
                    if (dst_fire) begin
                        rptr <= rptr + PW'(1);
                        dcnt <= dcnt + LW'(1);
                    end
                    // Credits bound occupancy: ost counts issued-but-not-popped words.
                    case ({add_fire, dst_fire})
                        2'b10:   ost <= ost + CW'(1);
                        2'b01:   ost <= ost - CW'(1);
                        default: ost <= ost;
                    endcase
                    case ({ret_fire, dst_fire})
                        2'b10:   fcnt <= fcnt + CW'(1);
                        2'b01:   fcnt <= fcnt - CW'(1);
                        default: fcnt <= fcnt;
                    endcase
                    if (dst_fire && dst_lst_exp) begin
                        state <= ST_IDLE;
                        acnt  <= '0;
                        dcnt  <= '0;
                        ost   <= '0;
                        fcnt  <= '0;
                        wptr  <= '0;
                        rptr  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(ret_fire && (fcnt == CW'(MAX_OUTSTD))))
        else $fatal(1, "return fifo overflow");

    assert property (@(posedge clk) disable iff (!rst_n)
        dst_fire |-> (mem[rptr][DW] == dst_lst_exp))
        else $error("bank last flag disagrees with length count");
endmodule

// File: tb/tb_eeg_aram_lane_init.sv
// tb/tb_eeg_aram_lane_init.sv - directed self-checking bench for eeg_aram_lane_init
module tb_eeg_aram_lane_init;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    eeg_aram_lane_init_if #(.ADD_AW(12), .DAT_DW(8), .LEN_DW(12)) bus ();

    eeg_aram_lane_init #(
        .ARAM_ADD_AW(12), .ARAM_DAT_DW(8), .ARAM_LEN_DW(12), .MAX_OUTSTD(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] bank_dat(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Bank model: one-cycle read latency, returns queued in issue order.
    logic [12:0] bq [$];
    always @(posedge clk) begin
        if (!rst_n) begin
            bq.delete();
            bus.atoe_dat_vld <= 1'b0;
            bus.atoe_dat_lst <= 1'b0;
            bus.atoe_dat_dat <= '0;
        end else begin
            if (bus.atoe_dat_vld && bus.atoe_dat_rdy) void'(bq.pop_front());
            if (bus.etoa_add_vld && bus.etoa_add_rdy) bq.push_back({bus.etoa_add_lst, bus.etoa_add_add});
            if (bq.size() > 0) begin
                bus.atoe_dat_vld <= 1'b1;
                bus.atoe_dat_lst <= bq[0][12];
                bus.atoe_dat_dat <= bank_dat(bq[0][11:0]);
            end else begin
                bus.atoe_dat_vld <= 1'b0;
                bus.atoe_dat_lst <= 1'b0;
            end
        end
    end

    task automatic cfg(input logic [1:0] cmd, input logic [11:0] base, input logic [11:0] len);
        bus.cfg_info_vld = 1'b1;
        bus.cfg_info_cmd = cmd;
        bus.cfg_base_add = base;
        bus.cfg_len_m1   = len;
        @(negedge clk);
        bus.cfg_info_vld = 1'b0;
    endtask

    task automatic test_reset;
        logic [9:0] obs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {bus.is_idle, bus.cfg_info_rdy, bus.src_dat_rdy, bus.atoe_dat_rdy, bus.etoa_dat_vld,
               bus.etoa_add_vld, bus.dst_dat_vld, bus.etoa_dat_lst, bus.etoa_add_lst, bus.dst_dat_lst};
        total++;
        if (obs !== 10'b11_0000_0000) $display("FAIL reset_flags got %b want 1100000000", obs);
        else passed++;
        total++;
        if ({bus.etoa_dat_add, bus.etoa_add_add, bus.etoa_dat_dat, bus.dst_dat_dat} !== 40'h0)
            $display("FAIL reset_payload got %h want 0",
                     {bus.etoa_dat_add, bus.etoa_add_add, bus.etoa_dat_dat, bus.dst_dat_dat});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write(input logic [11:0] base, input logic [11:0] len, input logic [7:0] d0,
                              input string name);
        logic [22:0] exp_v, obs_v;
        logic [11:0] ea;
        logic [7:0]  ed;
        cfg(2'b01, base, len);
        bus.src_dat_vld = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            ed = d0 + 8'(i);
            ea = base + 12'(i);
            bus.src_dat_dat = ed;
            #1;
            exp_v = {1'b1, 1'b1, (i == int'(len)), ea, ed};
            obs_v = {bus.etoa_dat_vld, bus.src_dat_rdy, bus.etoa_dat_lst, bus.etoa_dat_add, bus.etoa_dat_dat};
            total++;
            if (obs_v !== exp_v || bus.cfg_info_rdy !== 1'b0)
                $display("FAIL %s beat%0d got %h cfg_rdy=%b want %h cfg_rdy=0", name, i, obs_v, bus.cfg_info_rdy, exp_v);
            else passed++;
            @(negedge clk);
        end
        bus.src_dat_vld = 1'b0;
        #1;
        total++;
        if ({bus.is_idle, bus.etoa_dat_vld, bus.src_dat_rdy} !== 3'b100)
            $display("FAIL %s_idle got %b want 100", name, {bus.is_idle, bus.etoa_dat_vld, bus.src_dat_rdy});
        else passed++;
    endtask

    task automatic run_read(input logic [11:0] base, input logic [11:0] len, input int hold,
                            input int abort_at, input string name);
        int k = 0, issued = 0, ost = 0, ost_max = 0;
        bit done = 0, aborted = 0;
        logic [11:0] ea;
        cfg(2'b10, base, len);
        for (int cyc = 0; cyc < 300 && !done && !aborted; cyc++) begin
            bus.dst_dat_rdy = (cyc >= hold);
            #1;
            if (hold > 0 && cyc == hold) begin
                total++;
                if (issued != 4 || bus.etoa_add_vld !== 1'b0 || bus.atoe_dat_rdy !== 1'b1)
                    $display("FAIL %s_stall issued=%0d add_vld=%b atoe_rdy=%b want 4 0 1",
                             name, issued, bus.etoa_add_vld, bus.atoe_dat_rdy);
                else passed++;
            end
            if (bus.etoa_add_vld) begin
                ea = base + 12'(issued);
                total++;
                if (bus.etoa_add_add !== ea || bus.etoa_add_lst !== (issued == int'(len)))
                    $display("FAIL %s_addr%0d got %h/%b want %h/%b", name, issued,
                             bus.etoa_add_add, bus.etoa_add_lst, ea, (issued == int'(len)));
                else passed++;
                issued++;
                ost++;
            end
            if (bus.dst_dat_vld && bus.dst_dat_rdy) begin
                ea = base + 12'(k);
                total++;
                if (bus.dst_dat_dat !== bank_dat(ea) || bus.dst_dat_lst !== (k == int'(len)))
                    $display("FAIL %s_dst%0d got %h/%b want %h/%b", name, k,
                             bus.dst_dat_dat, bus.dst_dat_lst, bank_dat(ea), (k == int'(len)));
                else passed++;
                done = (k == int'(len));
                k++;
                ost--;
                aborted = (k == abort_at);
            end
            if (ost > ost_max) ost_max = ost;
            @(negedge clk);
        end
        if (!aborted) begin
            #1;
            total++;
            if (!done || k != int'(len) + 1 || issued != int'(len) + 1 || ost_max > 4 || bus.is_idle !== 1'b1)
                $display("FAIL %s_end done=%0d words=%0d issued=%0d ost_max=%0d idle=%b want 1 %0d %0d <=4 1",
                         name, done, k, issued, ost_max, bus.is_idle, int'(len) + 1, int'(len) + 1);
            else passed++;
        end
    endtask

    task automatic test_nop;
        cfg(2'b11, 12'h123, 12'h005);
        #1;
        total++;
        if ({bus.is_idle, bus.cfg_info_rdy, bus.src_dat_rdy, bus.atoe_dat_rdy, bus.etoa_add_vld} !== 5'b11000)
            $display("FAIL nop_cmd got %b want 11000",
                     {bus.is_idle, bus.cfg_info_rdy, bus.src_dat_rdy, bus.atoe_dat_rdy, bus.etoa_add_vld});
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        logic [6:0] obs;
        run_read(12'h200, 12'd7, 0, 3, "rd_abort");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        obs = {bus.is_idle, bus.etoa_add_vld, bus.etoa_dat_vld, bus.dst_dat_vld,
               bus.dst_dat_lst, bus.etoa_add_lst, bus.atoe_dat_rdy};
        total++;
        if (obs !== 7'b1000000) $display("FAIL rd_abort_reset got %b want 1000000", obs);
        else passed++;
        @(negedge clk);
        run_read(12'h040, 12'd1, 0, 99, "rd_after_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cfg_info_vld = 1'b0;
        bus.cfg_info_cmd = 2'b00;
        bus.cfg_base_add = '0;
        bus.cfg_len_m1   = '0;
        bus.src_dat_vld  = 1'b0;
        bus.src_dat_dat  = '0;
        bus.etoa_dat_rdy = 1'b1;
        bus.etoa_add_rdy = 1'b1;
        bus.dst_dat_rdy  = 1'b0;
        @(negedge clk);
        test_reset;
        test_write(12'h010, 12'd3, 8'hA0, "wr_basic");
        test_write(12'hFFE, 12'd3, 8'h10, "wr_wrap");
        run_read(12'h020, 12'd7, 0, 99, "rd_basic");
        run_read(12'h100, 12'd7, 20, 99, "rd_backpressure");
        run_read(12'h7F0, 12'd0, 0, 99, "rd_single");
        test_nop;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
